// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the sample averager and its per-channel accumulator:
//   - default widths of the averager datapath
//   - ACC_W, the accumulator width that rules out overflow for 2^MAX_LOG2_N adds
//   - clip-detect constants (a sample of all-zeros or all-ones is a clip)
//   - the measurement state enum
// -----------------------------------------------------------------------------
package dsp_pkg;

  localparam int unsigned DEF_SIG_WIDTH  = 12;
  localparam int unsigned DEF_MAX_LOG2_N = 10;
  localparam int unsigned DEF_LOG2_W     = 4;
  localparam int unsigned DEF_SETTLE_W   = 8;

  // Summing 2^MAX_LOG2_N full-scale samples needs exactly MAX_LOG2_N extra bits.
  localparam int unsigned ACC_W = DEF_SIG_WIDTH + DEF_MAX_LOG2_N;

  // Replicated to the sample width to form the all-zeros / all-ones patterns.
  localparam logic CLIP_LO_BIT = 1'b0;
  localparam logic CLIP_HI_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/avg_chan_accum.sv
// -----------------------------------------------------------------------------
// avg_chan_accum
// One averaging channel: accumulator with clear and add-enable, a divide by
// 2^log2_n implemented as a right shift, and clip detection on the incoming
// sample.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       clear the accumulator (wins over i_add)
//   i_add       add i_sample (zero-extended) to the accumulator
//   i_sample    incoming unsigned sample
//   i_log2_n    shift amount for the mean (already clamped by the caller)
//   o_avg       accumulator >> i_log2_n, truncated to the sample width
//   o_clip_hit  i_sample is all-zeros or all-ones
// -----------------------------------------------------------------------------
import dsp_pkg::*;

module avg_chan_accum #(
  parameter int unsigned SIG_WIDTH = DEF_SIG_WIDTH,
  parameter int unsigned ACC_WIDTH = ACC_W,
  parameter int unsigned LOG2_W    = DEF_LOG2_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_add,
  input  logic [SIG_WIDTH-1:0] i_sample,
  input  logic [LOG2_W-1:0]    i_log2_n,
  output logic [SIG_WIDTH-1:0] o_avg,
  output logic                 o_clip_hit
);

  logic [ACC_WIDTH-1:0] r_acc;

  // Running sum of the accepted samples of this channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (i_clr) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (i_add) begin
      r_acc <= r_acc + ACC_WIDTH'(i_sample);
    end else begin
      r_acc <= r_acc;
    end
  end

  // With exactly 2^log2_n samples summed the shifted value always fits the
  // sample width, so the truncating cast loses nothing.
  assign o_avg      = SIG_WIDTH'(r_acc >> i_log2_n);
  assign o_clip_hit = (i_sample == {SIG_WIDTH{CLIP_LO_BIT}}) ||
                      (i_sample == {SIG_WIDTH{CLIP_HI_BIT}});

endmodule

// File: rtl/sample_averager.sv
// -----------------------------------------------------------------------------
// sample_averager
// Per measurement: discard `settle` samples after a frequency step, average
// 2^log2_n A/B sample pairs, then present one result over valid/ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 arm a measurement (IDLE only); latches log2_n, settle
//   abort                 return to IDLE from any state, drop any result
//   log2_n, settle        averaging exponent (clamped to MAX_LOG2_N), discards
//   in_valid, in_a, in_b  sample strobe and filtered A/B samples
//   busy                  high in SETTLE, ACCUM and DONE
//   out_valid, out_ready  result handshake
//   out_a, out_b          averaged samples (truncated mean)
//   out_clip              some accumulated sample was all-zeros or all-ones
// -----------------------------------------------------------------------------
import dsp_pkg::*;

module sample_averager #(
  parameter int unsigned SIG_WIDTH  = DEF_SIG_WIDTH,
  parameter int unsigned MAX_LOG2_N = DEF_MAX_LOG2_N,
  parameter int unsigned LOG2_W     = DEF_LOG2_W,
  parameter int unsigned SETTLE_W   = DEF_SETTLE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LOG2_W-1:0]    log2_n,
  input  logic [SETTLE_W-1:0]  settle,
  input  logic                 in_valid,
  input  logic [SIG_WIDTH-1:0] in_a,
  input  logic [SIG_WIDTH-1:0] in_b,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIG_WIDTH-1:0] out_a,
  output logic [SIG_WIDTH-1:0] out_b,
  output logic                 out_clip
);

  localparam int unsigned        ACC_WIDTH = SIG_WIDTH + MAX_LOG2_N;
  // Sample counter must reach 2^MAX_LOG2_N - 1, plus headroom for the final increment.
  localparam int unsigned        CNT_W     = MAX_LOG2_N + 1;
  localparam logic [LOG2_W-1:0]  LOG2_MAX  = LOG2_W'(MAX_LOG2_N);

  state_e               r_state;
  logic                 r_busy;
  logic                 r_fin;
  logic                 r_clip;
  logic                 r_out_valid;
  logic                 r_out_clip;
  logic [SIG_WIDTH-1:0] r_out_a;
  logic [SIG_WIDTH-1:0] r_out_b;
  logic [LOG2_W-1:0]    r_log2_n;
  logic [SETTLE_W-1:0]  r_settle;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_start_ok;
  logic                 w_clr;
  logic                 w_add;
  logic                 w_last;
  logic [LOG2_W-1:0]    w_log2_clamped;
  logic [SIG_WIDTH-1:0] w_avg_a;
  logic [SIG_WIDTH-1:0] w_avg_b;
  logic                 w_clip_a;
  logic                 w_clip_b;

  assign w_start_ok     = start && !abort && (r_state == IDLE);
  assign w_clr          = abort || w_start_ok;
  assign w_add          = in_valid && !abort && (r_state == ACCUM);
  assign w_last         = (r_cnt == ((CNT_W'(1) << r_log2_n) - CNT_W'(1)));
  assign w_log2_clamped = (log2_n > LOG2_MAX) ? LOG2_MAX : log2_n;

  avg_chan_accum #(
    .SIG_WIDTH (SIG_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .LOG2_W    (LOG2_W)
  ) u_chan_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_add      (w_add),
    .i_sample   (in_a),
    .i_log2_n   (r_log2_n),
    .o_avg      (w_avg_a),
    .o_clip_hit (w_clip_a)
  );

  avg_chan_accum #(
    .SIG_WIDTH (SIG_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .LOG2_W    (LOG2_W)
  ) u_chan_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_add      (w_add),
    .i_sample   (in_b),
    .i_log2_n   (r_log2_n),
    .o_avg      (w_avg_b),
    .o_clip_hit (w_clip_b)
  );

  // Measurement FSM with counters, clip flag and registered result/handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_fin       <= 1'b0;
      r_clip      <= 1'b0;
      r_log2_n    <= {LOG2_W{1'b0}};
      r_settle    <= {SETTLE_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_out_clip  <= 1'b0;
      r_out_a     <= {SIG_WIDTH{1'b0}};
      r_out_b     <= {SIG_WIDTH{1'b0}};
    end else if (abort) begin
      // Output data is kept; only the handshake is withdrawn.
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_fin       <= 1'b0;
      r_clip      <= 1'b0;
      r_settle    <= {SETTLE_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_log2_n <= w_log2_clamped;
            r_settle <= settle;
            r_cnt    <= {CNT_W{1'b0}};
            r_clip   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (settle != {SETTLE_W{1'b0}}) ? SETTLE : ACCUM;
          end
        end
        SETTLE: begin
          if (in_valid) begin
            r_settle <= r_settle - SETTLE_W'(1);
            if (r_settle == SETTLE_W'(1)) begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_clip_a || w_clip_b) begin
              r_clip <= 1'b1;
            end
            if (w_last) begin
              r_state <= DONE;
              r_fin   <= 1'b1;
            end
          end
        end
        DONE: begin
          // r_fin marks the cycle after the last add, when the sums are final.
          if (r_fin) begin
            r_fin       <= 1'b0;
            r_out_a     <= w_avg_a;
            r_out_b     <= w_avg_b;
            r_out_clip  <= r_clip;
            r_out_valid <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_fin       <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_clip  = r_out_clip;

endmodule

// File: tb/tb_sample_averager.sv
module tb_sample_averager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  log2_n;
  logic [7:0]  settle;
  logic        in_valid;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_a;
  logic [11:0] out_b;
  logic        out_clip;

  int total = 0;
  int bad   = 0;

  sample_averager dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .log2_n    (log2_n),
    .settle    (settle),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_clip  (out_clip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sample(input logic [11:0] a, input logic [11:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_meas(input logic [3:0] l2n, input logic [7:0] st);
    start  = 1'b1;
    log2_n = l2n;
    settle = st;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  function automatic logic [11:0] rand_sample(input bit allow_clip);
    if (allow_clip && ($urandom_range(0, 7) == 0))
      return ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'h000;
    else
      return 12'($urandom_range(1, 4094));
  endfunction

  // Reference: the result is the plain truncated mean of the accumulated
  // samples; settle samples are sent but never enter the model.
  task automatic run_measure(input int l2n, input int st, input bit allow_clip,
                             input int force_idx, input int gap_max, input bit do_hs,
                             output logic [11:0] ea, output logic [11:0] eb);
    int          eff;
    int          n;
    longint      sa;
    longint      sb;
    bit          clip;
    logic [11:0] a;
    logic [11:0] b;
    logic [3:0]  l2n_v;
    logic [7:0]  st_v;
    eff   = (l2n > 10) ? 10 : l2n;
    n     = 1 << eff;
    sa    = 0;
    sb    = 0;
    clip  = 1'b0;
    l2n_v = 4'(l2n);
    st_v  = 8'(st);
    start_meas(l2n_v, st_v);
    for (int i = 0; i < st; i++) begin
      idle($urandom_range(0, gap_max));
      drive_sample(rand_sample(1'b1), rand_sample(1'b1));
    end
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gap_max));
      a = rand_sample(allow_clip);
      b = rand_sample(allow_clip);
      if (i == force_idx) a = 12'hFFF;
      sa += longint'(a);
      sb += longint'(b);
      if (a == 12'h000 || a == 12'hFFF || b == 12'h000 || b == 12'hFFF) clip = 1'b1;
      drive_sample(a, b);
    end
    ea = 12'(sa >> eff);
    eb = 12'(sb >> eff);
    check("valid_not_before_latency", 32'(out_valid), 32'd0);
    idle(1);
    check("valid_after_last", 32'(out_valid), 32'd1);
    check("mean_a", 32'(out_a), 32'(ea));
    check("mean_b", 32'(out_b), 32'(eb));
    check("clip", 32'(out_clip), 32'(clip));
    check("busy_done", 32'(busy), 32'd1);
    if (do_hs) begin
      repeat ($urandom_range(0, 3)) begin
        drive_sample(rand_sample(1'b1), rand_sample(1'b1));
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_a", 32'(out_a), 32'(ea));
      end
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("valid_after_hs", 32'(out_valid), 32'd0);
      check("busy_after_hs", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] ea;
    logic [11:0] eb;
    logic [11:0] sa_v;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    log2_n    = 4'd0;
    settle    = 8'd0;
    in_valid  = 1'b0;
    in_a      = 12'd0;
    in_b      = 12'd0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_a", 32'(out_a), 32'd0);
    check("rst_b", 32'(out_b), 32'd0);
    check("rst_clip", 32'(out_clip), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic average: two settle samples, then four averaged
    start_meas(4'd2, 8'd2);
    check("basic_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 6; i++) drive_sample(12'(10 * i), 12'd100);
    check("basic_valid_early", 32'(out_valid), 32'd0);
    idle(1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_a", 32'(out_a), 32'd45);
    check("basic_b", 32'(out_b), 32'd100);
    check("basic_clip", 32'(out_clip), 32'd0);

    // Handshake hold while samples keep arriving
    for (int i = 0; i < 20; i++) begin
      drive_sample(rand_sample(1'b1), rand_sample(1'b1));
      check("hold_valid20", 32'(out_valid), 32'd1);
      check("hold_a20", 32'(out_a), 32'd45);
      check("hold_b20", 32'(out_b), 32'd100);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("hs_valid", 32'(out_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_keep_a", 32'(out_a), 32'd45);

    // Randomized measurements against the reference
    for (int k = 0; k < 6; k++)
      run_measure($urandom_range(0, 5), $urandom_range(0, 4), 1'b1, -1,
                  $urandom_range(0, 2), 1'b1, ea, eb);

    // Clip and clamp: log2_n=15 behaves as 10, one full-scale A sample
    run_measure(15, 0, 1'b0, $urandom_range(0, 1023), 0, 1'b1, ea, eb);

    // Boundary: start and in_valid together, log2_n=0 pass-through
    start    = 1'b1;
    log2_n   = 4'd0;
    settle   = 8'd0;
    in_valid = 1'b1;
    in_a     = 12'd999;
    in_b     = 12'd999;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("pass_not_taken", 32'(out_valid), 32'd0);
    drive_sample(12'd1234, 12'd77);
    check("pass_valid_early", 32'(out_valid), 32'd0);
    idle(1);
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_a", 32'(out_a), 32'd1234);
    check("pass_b", 32'(out_b), 32'd77);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("pass_hs", 32'(out_valid), 32'd0);

    // Abort during SETTLE
    start_meas(4'd3, 8'd5);
    drive_sample(12'd5, 12'd5);
    drive_sample(12'd6, 12'd6);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    check("abort_settle_busy", 32'(busy), 32'd0);
    check("abort_settle_valid", 32'(out_valid), 32'd0);

    // Abort during ACCUM, then a full run must be unaffected
    start_meas(4'd3, 8'd0);
    for (int i = 0; i < 3; i++) drive_sample(12'd4000, 12'd4000);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    check("abort_accum_busy", 32'(busy), 32'd0);
    run_measure(3, 1, 1'b1, -1, 1, 1'b1, ea, eb);

    // abort beats start in IDLE
    abort = 1'b1;
    start = 1'b1;
    idle(1);
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    idle(1);
    check("abort_start_busy2", 32'(busy), 32'd0);

    // In DONE: start ignored, then abort together with out_ready
    run_measure(2, 1, 1'b1, -1, 1, 1'b0, ea, eb);
    start_meas(4'd0, 8'd0);
    check("done_start_valid", 32'(out_valid), 32'd1);
    check("done_start_a", 32'(out_a), 32'(ea));
    check("done_start_busy", 32'(busy), 32'd1);
    abort     = 1'b1;
    out_ready = 1'b1;
    idle(1);
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abort_done_valid", 32'(out_valid), 32'd0);
    check("abort_done_busy", 32'(busy), 32'd0);
    idle(2);
    check("abort_done_stays", 32'(out_valid), 32'd0);

    // Reset mid-ACCUM, asserted between clock edges
    run_measure(1, 0, 1'b0, -1, 0, 1'b1, ea, eb);
    sa_v = ea;
    start_meas(4'd2, 8'd0);
    drive_sample(12'd300, 12'd300);
    drive_sample(12'd301, 12'd301);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_a", 32'(out_a), 32'(sa_v));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_a", 32'(out_a), 32'd0);
    check("async_rst_b", 32'(out_b), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_clip", 32'(out_clip), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_measure(2, 2, 1'b1, -1, 1, 1'b1, ea, eb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
